// File: rtl/ofm_writeback_packer.sv
// ofm_writeback_packer: packs OFM lane bytes into 128-bit words, buffers them and writes them to global BRAM at base+index.
// Optional feature macro OFM_WB_STALL_CNT_EN adds the stall_cycles counter output.
module ofm_writeback_packer #(
  parameter int LANES      = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr_OFM,
  input  logic [31:0]         size_OFM,
  input  logic                ofm_valid,
  input  logic [LANES*8-1:0]  ofm_data,
  output logic                ofm_ready,
  input  logic                wr_grant,
  output logic                we_global,
  output logic [ADDR_W-1:0]   wr_addr_global,
  output logic [127:0]        data_out_global,
  output logic                busy,
  output logic                done
`ifdef OFM_WB_STALL_CNT_EN
  , output logic [31:0]       stall_cycles
`endif
);
  localparam int BW    = LANES * 8;
  localparam int BEATS = 16 / LANES;
  localparam int PW    = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, PACK, DRAIN, DONE} state_t;
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d, word_idx_q, word_idx_d, addr_q, addr_d;
  logic [31:0]         byte_rem_q, byte_rem_d, take;
  logic [4:0]          fill_q, fill_d;
  logic [127:0]        pack_q, pack_d, data_q, data_d, word_in;
  logic [127:0]        fifo_q [FIFO_DEPTH];
  logic [127:0]        fifo_d [FIFO_DEPTH];
  logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW:0]         cnt_q, cnt_d;
  logic                we_q, we_d, busy_q, busy_d, done_q, done_d;
  logic                full, empty, pop, push, accept, last_beat, start_ok;
  logic [BW-1:0]       lane_data;
  // Handshake, lane masking and pack-register merge for the current beat
  always_comb begin
    full      = cnt_q == (PW+1)'(FIFO_DEPTH);
    empty     = cnt_q == '0;
    pop       = !empty && wr_grant;
    ofm_ready = (state_q == PACK) && (!full || pop);
    accept    = ofm_valid && ofm_ready;
    start_ok  = start && (state_q == IDLE);
    last_beat = byte_rem_q <= 32'(LANES);
    take      = last_beat ? byte_rem_q : 32'(LANES);
    lane_data = '0;
    for (int k = 0; k < LANES; k++)
      lane_data[8*k +: 8] = (32'(k) < byte_rem_q) ? ofm_data[8*k +: 8] : 8'h00;
    word_in   = pack_q | (128'(lane_data) << (fill_q * BW));
    push      = accept && (fill_q == 5'(BEATS-1) || last_beat);
  end
  // Control FSM next state plus busy/done, registered for glitch-free outputs
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = start ? (size_OFM == '0 ? DONE : PACK) : IDLE;
      PACK:  state_d = (accept && last_beat) ? DRAIN : PACK;
      DRAIN: state_d = empty ? DONE : DRAIN;
      DONE:  state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    done_d = state_q == DONE;
  end
  // Byte accounting, pack register and write-side address/data capture
  always_comb begin
    base_d     = start_ok ? base_addr_OFM : base_q;
    byte_rem_d = start_ok ? size_OFM : accept ? byte_rem_q - take : byte_rem_q;
    fill_d     = (start_ok || push) ? 5'd0 : accept ? fill_q + 5'd1 : fill_q;
    pack_d     = (start_ok || push) ? '0 : accept ? word_in : pack_q;
    word_idx_d = start_ok ? '0 : pop ? word_idx_q + 1'b1 : word_idx_q;
    we_d       = pop;
    addr_d     = pop ? base_q + word_idx_q : addr_q;
    data_d     = pop ? fifo_q[rptr_q] : data_q;
  end
  // Word FIFO storage and pointers; push and pop may coincide even when full
  always_comb begin
    fifo_d = fifo_q;
    if (push) fifo_d[wptr_q] = word_in;
    wptr_d = wptr_q + PW'(push);
    rptr_d = rptr_q + PW'(pop);
    cnt_d  = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  // State registers; asynchronous reset abandons any transfer without writing
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q    <= IDLE;
      base_q     <= '0;
      word_idx_q <= '0;
      addr_q     <= '0;
      byte_rem_q <= '0;
      fill_q     <= '0;
      pack_q     <= '0;
      data_q     <= '0;
      fifo_q     <= '{default: '0};
      wptr_q     <= '0;
      rptr_q     <= '0;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      word_idx_q <= word_idx_d;
      addr_q     <= addr_d;
      byte_rem_q <= byte_rem_d;
      fill_q     <= fill_d;
      pack_q     <= pack_d;
      data_q     <= data_d;
      fifo_q     <= fifo_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      cnt_q      <= cnt_d;
      we_q       <= we_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  assign we_global       = we_q;
  assign wr_addr_global  = addr_q;
  assign data_out_global = data_q;
  assign busy            = busy_q;
  assign done            = done_q;
`ifdef OFM_WB_STALL_CNT_EN
  logic [31:0] stall_q, stall_d;
  // Saturating count of cycles a buffered word waits for the write grant
  always_comb
    stall_d = start_ok ? '0 : (!empty && !wr_grant && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  // Stall counter register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) stall_q <= '0;
    else          stall_q <= stall_d;
  assign stall_cycles = stall_q;
`endif
endmodule
